mc_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM: sequences the shared datapath through IF/ID/EX/MEM/WB.

---
 rtl/mc_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) driving a shared datapath and one req/ack memory port.
// Optional performance counters cycCnt/instCnt are built when MC_CTRL_PERF_EN is defined.
module mc_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic        memAck,
  input  logic        brCond,
  output logic        memReq,
  output logic        memWr,
  output logic        iorD,
  output logic        irWr,
  output logic        pcWr,
  output logic [1:0]  pcSrc,
  output logic        regWr,
  output logic [1:0]  regDst,
  output logic        memToReg,
  output logic        aluSrc,
  output logic        extOp,
  output logic [4:0]  aluOp,
  output logic        retire,
  output logic        illegal,
  output logic        busErr,
  output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycCnt,
  output logic [31:0] instCnt
`endif
);

  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_SLTU = 5'b01001;
  localparam logic [4:0] OP_LUI  = 5'b10000;

  // Counter only ever needs to reach TIMEOUT-1.
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t         st, nxt;
  logic [CW-1:0]  wcnt;
  logic           tmo;

  logic [5:0] op, fn;
  logic       known, is_r, is_j, is_jal, is_jr, is_jalr, is_br, is_imm, is_ld, is_st;
  logic [4:0] dec_alu;
  logic       dec_ext;
  logic       unused;

  logic       req, wr, iord, irwr, pcwr, regwr, m2r, alusrc, extop, ret, ill, berr;
  logic [1:0] pcsrc, regdst;
  logic [4:0] aluop;

  assign op     = ins[31:26];
  assign fn     = ins[5:0];
  assign unused = ^ins[25:6];

  always_comb begin
    known = 1'b0; is_r = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_jalr = 1'b0;
    is_br = 1'b0; is_imm = 1'b0; is_ld = 1'b0; is_st = 1'b0;
    dec_alu = OP_ADD; dec_ext = 1'b0;
    case (op)
      6'h00: begin
        known = 1'b1;
        case (fn)
          6'h08:        is_jr = 1'b1;
          6'h09:        is_jalr = 1'b1;
          6'h20, 6'h21: begin is_r = 1'b1; dec_alu = OP_ADD;  end
          6'h22, 6'h23: begin is_r = 1'b1; dec_alu = OP_SUB;  end
          6'h24:        begin is_r = 1'b1; dec_alu = OP_AND;  end
          6'h25:        begin is_r = 1'b1; dec_alu = OP_OR;   end
          6'h26:        begin is_r = 1'b1; dec_alu = OP_XOR;  end
          6'h2A:        begin is_r = 1'b1; dec_alu = OP_SLT;  end
          6'h2B:        begin is_r = 1'b1; dec_alu = OP_SLTU; end
          default:      known = 1'b0;
        endcase
      end
      6'h02: begin known = 1'b1; is_j = 1'b1; end
      6'h03: begin known = 1'b1; is_jal = 1'b1; end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
        known = 1'b1; is_br = 1'b1;
        dec_alu = (op == 6'h04 || op == 6'h05) ? OP_SUB : OP_ADD;
      end
      6'h09: begin known = 1'b1; is_imm = 1'b1; dec_alu = OP_ADD;  dec_ext = 1'b1; end
      6'h0A: begin known = 1'b1; is_imm = 1'b1; dec_alu = OP_SLT;  dec_ext = 1'b1; end
      6'h0B: begin known = 1'b1; is_imm = 1'b1; dec_alu = OP_SLTU; end
      6'h0C: begin known = 1'b1; is_imm = 1'b1; dec_alu = OP_AND;  end
      6'h0D: begin known = 1'b1; is_imm = 1'b1; dec_alu = OP_OR;   end
      6'h0E: begin known = 1'b1; is_imm = 1'b1; dec_alu = OP_XOR;  end
      6'h0F: begin known = 1'b1; is_imm = 1'b1; dec_alu = OP_LUI;  end
      6'h20, 6'h23, 6'h24: begin known = 1'b1; is_ld = 1'b1; end
      6'h28, 6'h2B:        begin known = 1'b1; is_st = 1'b1; end
      default: known = 1'b0;
    endcase
  end

  assign tmo = (TIMEOUT != 0) && (wcnt == CW'(TLIM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_IF;
    else     st <= nxt;
  end

  // Counter restarts whenever a request completes, aborts, or is not active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          wcnt <= '0;
    else if (req && !memAck && !tmo)  wcnt <= wcnt + 1'b1;
    else                              wcnt <= '0;
  end

  always_comb begin
    nxt = st;
    req = 1'b0; wr = 1'b0; iord = 1'b0; irwr = 1'b0; pcwr = 1'b0; pcsrc = 2'b00;
    regwr = 1'b0; regdst = 2'b00; m2r = 1'b0; alusrc = 1'b0; extop = 1'b0;
    aluop = OP_ADD; ret = 1'b0; ill = 1'b0; berr = 1'b0;
    case (st)
      S_IF: begin
        req = 1'b1;
        if (memAck) begin
          irwr = 1'b1; pcwr = 1'b1; nxt = S_ID;
        end else if (tmo) begin
          berr = 1'b1; nxt = S_IF;
        end
      end
      S_ID: begin
        nxt = S_EX;
        if (!known) begin
          ill = 1'b1; nxt = S_IF;
        end else if (is_j || is_jal) begin
          pcwr = 1'b1; pcsrc = 2'b10; ret = 1'b1; nxt = S_IF;
          if (is_jal) begin regwr = 1'b1; regdst = 2'b10; end
        end else if (is_jr || is_jalr) begin
          pcwr = 1'b1; pcsrc = 2'b11; ret = 1'b1; nxt = S_IF;
          if (is_jalr) begin regwr = 1'b1; regdst = 2'b01; end
        end
      end
      S_EX: begin
        aluop = dec_alu;
        nxt   = S_WB;
        if (is_ld || is_st) begin
          alusrc = 1'b1; extop = 1'b1; aluop = OP_ADD; nxt = S_MEM;
        end else if (is_imm) begin
          alusrc = 1'b1; extop = dec_ext;
        end else if (is_br) begin
          pcwr = brCond; pcsrc = 2'b01; ret = 1'b1; nxt = S_IF;
        end
      end
      S_MEM: begin
        req = 1'b1; iord = 1'b1; wr = is_st;
        if (memAck) begin
          if (is_st) begin ret = 1'b1; nxt = S_IF; end
          else     nxt = S_WB;
        end else if (tmo) begin
          berr = 1'b1; nxt = S_IF;
        end
      end
      S_WB: begin
        regwr = 1'b1; ret = 1'b1; nxt = S_IF;
        regdst = is_r ? 2'b01 : 2'b00;
        m2r = is_ld;
      end
      default: nxt = S_IF;
    endcase
  end

  // Reset forces every output low immediately, independent of the clock.
  assign memReq   = req    & ~rst;
  assign memWr    = wr     & ~rst;
  assign iorD     = iord   & ~rst;
  assign irWr     = irwr   & ~rst;
  assign pcWr     = pcwr   & ~rst;
  assign pcSrc    = pcsrc  & {2{~rst}};
  assign regWr    = regwr  & ~rst;
  assign regDst   = regdst & {2{~rst}};
  assign memToReg = m2r    & ~rst;
  assign aluSrc   = alusrc & ~rst;
  assign extOp    = extop  & ~rst;
  assign aluOp    = aluop  & {5{~rst}};
  assign retire   = ret    & ~rst;
  assign illegal  = ill    & ~rst;
  assign busErr   = berr   & ~rst;
  assign state    = st     & {3{~rst}};

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycCnt  <= '0;
      instCnt <= '0;
    end else begin
      cycCnt  <= cycCnt + 32'd1;
      instCnt <= instCnt + 32'(ret);
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: driver queues hand-computed per-cycle expectations, monitor compares on negedge.
module tb_mc_ctrl;
  logic        clk = 1'b0, rst = 1'b1, memAck = 1'b0, brCond = 1'b0;
  logic [31:0] ins = 32'h0;
  logic        memReq, memWr, iorD, irWr, pcWr, regWr, memToReg, aluSrc, extOp, retire, illegal, busErr;
  logic [1:0]  pcSrc, regDst;
  logic [4:0]  aluOp;
  logic [2:0]  state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycCnt, instCnt;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, wr, iord, irwr, pcwr;
    logic [1:0] pcsrc;
    logic       regwr;
    logic [1:0] regdst;
    logic       m2r, alusrc, extop;
    logic [4:0] aluop;
    logic       ret, ill, berr;
  } o_t;

  typedef struct {
    o_t          o;
    bit          pchk;
    int unsigned cyc;
    int unsigned inst;
    string       nm;
  } rec_t;

  rec_t q[$];
  int   pass_n = 0, tot_n = 0;

  mc_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ins(ins), .memAck(memAck), .brCond(brCond),
    .memReq(memReq), .memWr(memWr), .iorD(iorD), .irWr(irWr), .pcWr(pcWr), .pcSrc(pcSrc),
    .regWr(regWr), .regDst(regDst), .memToReg(memToReg), .aluSrc(aluSrc), .extOp(extOp),
    .aluOp(aluOp), .retire(retire), .illegal(illegal), .busErr(busErr), .state(state)
`ifdef MC_CTRL_PERF_EN
    , .cycCnt(cycCnt), .instCnt(instCnt)
`endif
  );

  // Monitor
  initial begin
    rec_t r;
    o_t   g;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        r = q.pop_front();
        g = {state, memReq, memWr, iorD, irWr, pcWr, pcSrc, regWr, regDst,
             memToReg, aluSrc, extOp, aluOp, retire, illegal, busErr};
        tot_n++;
        if (g === r.o) pass_n++;
        else $display("FAIL %s: got %h expected %h", r.nm, g, r.o);
`ifdef MC_CTRL_PERF_EN
        if (r.pchk) begin
          tot_n++;
          if (cycCnt === r.cyc && instCnt === r.inst) pass_n++;
          else $display("FAIL %s perf: got cyc=%0d inst=%0d expected cyc=%0d inst=%0d",
                        r.nm, cycCnt, instCnt, r.cyc, r.inst);
        end
`endif
      end
    end
  end

  function automatic o_t z(input logic [2:0] s);
    o_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  task automatic step_p(input logic r, input logic a, input logic b, input o_t e, input string nm,
                        input bit pc, input int unsigned c, input int unsigned i);
    rec_t x;
    rst = r; memAck = a; brCond = b;
    x.o = e; x.pchk = pc; x.cyc = c; x.inst = i; x.nm = nm;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic a, input logic b, input o_t e, input string nm);
    step_p(r, a, b, e, nm, 1'b0, 0, 0);
  endtask

  function automatic o_t e_fetch();
    o_t e;
    e = z(3'd0); e.req = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
    return e;
  endfunction

  function automatic o_t e_fwait();
    o_t e;
    e = z(3'd0); e.req = 1'b1;
    return e;
  endfunction

  function automatic o_t e_wb(input logic rd, input logic m2r);
    o_t e;
    e = z(3'd4); e.regwr = 1'b1; e.ret = 1'b1; e.regdst = rd ? 2'b01 : 2'b00; e.m2r = m2r;
    return e;
  endfunction

  function automatic o_t e_mem(input logic w, input logic rt, input logic be);
    o_t e;
    e = z(3'd3); e.req = 1'b1; e.iord = 1'b1; e.wr = w; e.ret = rt; e.berr = be;
    return e;
  endfunction

  function automatic o_t e_exls();
    o_t e;
    e = z(3'd2); e.alusrc = 1'b1; e.extop = 1'b1;
    return e;
  endfunction

  task automatic fetch_id(input logic [31:0] w, input string nm);
    ins = w;
    step(0, 1, 0, e_fetch(), {nm, " IF"});
    step(0, 0, 0, z(3'd1), {nm, " ID"});
  endtask

  // Driver
  initial begin
    o_t e;
    @(posedge clk); #1;
    step(1, 1, 0, z(3'd0), "reset ack");
    step(1, 0, 0, z(3'd0), "reset");

    // ADDU, memAck held high outside IF/MEM must be ignored
    ins = 32'h00221821;
    step(0, 1, 0, e_fetch(), "addu IF");
    step(0, 1, 0, z(3'd1), "addu ID");
    step(0, 1, 0, z(3'd2), "addu EX");
    step(0, 1, 0, e_wb(1, 0), "addu WB");

    fetch_id(32'h00221823, "subu");
    e = z(3'd2); e.aluop = 5'b00001;
    step(0, 0, 0, e, "subu EX");
    step(0, 0, 0, e_wb(1, 0), "subu WB");

    // LW, ack in the 4th MEM cycle (coincides with the timeout cycle)
    fetch_id(32'h8C220004, "lw");
    step(0, 0, 0, e_exls(), "lw EX");
    for (int k = 0; k < 3; k++) step(0, 0, 0, e_mem(0, 0, 0), "lw MEM wait");
    step(0, 1, 0, e_mem(0, 0, 0), "lw MEM ack");
    step(0, 0, 0, e_wb(0, 1), "lw WB");

    fetch_id(32'h10220003, "beq t");
    e = z(3'd2); e.aluop = 5'b00001; e.pcwr = 1'b1; e.pcsrc = 2'b01; e.ret = 1'b1;
    step(0, 0, 1, e, "beq taken EX");
    fetch_id(32'h10220003, "beq nt");
    e.pcwr = 1'b0;
    step(0, 0, 0, e, "beq not-taken EX");

    fetch_id(32'h1C200002, "bgtz");
    e = z(3'd2); e.pcwr = 1'b1; e.pcsrc = 2'b01; e.ret = 1'b1;
    step(0, 0, 1, e, "bgtz EX");

    fetch_id(32'h34220005, "ori");
    e = z(3'd2); e.alusrc = 1'b1; e.aluop = 5'b00101;
    step(0, 0, 0, e, "ori EX");
    step(0, 0, 0, e_wb(0, 0), "ori WB");

    fetch_id(32'h2822FFFF, "slti");
    e = z(3'd2); e.alusrc = 1'b1; e.extop = 1'b1; e.aluop = 5'b00010;
    step(0, 0, 0, e, "slti EX");
    step(0, 0, 0, e_wb(0, 0), "slti WB");

    // Jumps resolve in ID
    ins = 32'h08000010;
    step(0, 1, 0, e_fetch(), "j IF");
    e = z(3'd1); e.pcwr = 1'b1; e.pcsrc = 2'b10; e.ret = 1'b1;
    step(0, 0, 0, e, "j ID");
    ins = 32'h0C000010;
    step(0, 1, 0, e_fetch(), "jal IF");
    e.regwr = 1'b1; e.regdst = 2'b10;
    step(0, 0, 0, e, "jal ID");
    ins = 32'h03E00008;
    step(0, 1, 0, e_fetch(), "jr IF");
    e = z(3'd1); e.pcwr = 1'b1; e.pcsrc = 2'b11; e.ret = 1'b1;
    step(0, 0, 0, e, "jr ID");
    ins = 32'h03E0F809;
    step(0, 1, 0, e_fetch(), "jalr IF");
    e.regwr = 1'b1; e.regdst = 2'b01;
    step(0, 0, 0, e, "jalr ID");

    ins = 32'hFC000000;
    step(0, 1, 0, e_fetch(), "illop IF");
    e = z(3'd1); e.ill = 1'b1;
    step(0, 0, 0, e, "illop ID");

    // IF timeout after 4 unacknowledged cycles, then refetch
    for (int k = 0; k < 3; k++) step(0, 0, 0, e_fwait(), "if wait");
    e = e_fwait(); e.berr = 1'b1;
    step(0, 0, 0, e, "if timeout");
    step(0, 0, 0, e_fwait(), "if refetch");
    ins = 32'h08000010;
    step(0, 1, 0, e_fetch(), "refetch ack");
    e = z(3'd1); e.pcwr = 1'b1; e.pcsrc = 2'b10; e.ret = 1'b1;
    step(0, 0, 0, e, "refetch j ID");

    ins = 32'h00000001;
    step(0, 1, 0, e_fetch(), "illfn IF");
    e = z(3'd1); e.ill = 1'b1;
    step(0, 0, 0, e, "illfn ID");

    fetch_id(32'hAC220000, "sw");
    step(0, 0, 0, e_exls(), "sw EX");
    step(0, 1, 0, e_mem(1, 1, 0), "sw MEM ack");

    // MEM timeout aborts the store
    fetch_id(32'hAC220000, "sw to");
    step(0, 0, 0, e_exls(), "sw to EX");
    for (int k = 0; k < 3; k++) step(0, 0, 0, e_mem(1, 0, 0), "sw to MEM wait");
    step(0, 0, 0, e_mem(1, 0, 1), "sw MEM timeout");

    // Async reset in the middle of a store
    fetch_id(32'hAC220000, "sw rst");
    step(0, 0, 0, e_exls(), "sw rst EX");
    step(0, 0, 0, e_mem(1, 0, 0), "sw rst MEM");
    step_p(1, 1, 0, z(3'd0), "mid reset", 1'b1, 0, 0);
    step_p(1, 0, 0, z(3'd0), "mid reset2", 1'b1, 0, 0);
    ins = 32'h08000010;
    step_p(0, 1, 0, e_fetch(), "post reset IF", 1'b1, 0, 0);
    e = z(3'd1); e.pcwr = 1'b1; e.pcsrc = 2'b10; e.ret = 1'b1;
    step_p(0, 0, 0, e, "post reset j ID", 1'b1, 1, 0);
    step_p(0, 0, 0, e_fwait(), "post reset IF2", 1'b1, 2, 1);

    @(negedge clk); #1;
    tot_n++;
    if (q.size() == 0) pass_n++;
    else $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
